// File: rtl/umi_arb_pkg.sv
// ---------------------------------------------------------------------------
// umi_arb_pkg
// Shared definitions for the UMI switch output arbiter:
//   arb_mode_e   - arbitration mode encodings carried on the arbmode port
//   lock_state_e - grant lock state (open arbitration / held on registered grant)
//   oh_to_idx()  - one-hot vector (up to 32 bits) to bit index
// ---------------------------------------------------------------------------
package umi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_RR   = 2'b00,
        ARB_PRIO = 2'b01,
        ARB_AGE  = 2'b10
    } arb_mode_e;

    typedef enum logic {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_e;

    // Returns the index of the highest set bit; callers only pass one-hot
    // or all-zero vectors, where all-zero yields 0.
    function automatic int unsigned oh_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (oh[k]) begin
                idx = k;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/umi_arb_pick.sv
// ---------------------------------------------------------------------------
// umi_arb_pick
// First-set-bit picker with wrap-around.  Scans req_i starting at start_i,
// moving upward and wrapping modulo N, and returns a one-hot vector of the
// first set bit found (all-zero when req_i is empty).
// Ports:
//   req_i   [N]   candidate vector
//   start_i [IW]  index where the search begins (must be < N)
//   gnt_o   [N]   one-hot winner
// ---------------------------------------------------------------------------
module umi_arb_pick
    import umi_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  gnt_o
);

    int unsigned   idx;
    logic [IW-1:0] pos;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = int'(start_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            pos = IW'(idx);
            if (!found && req_i[pos]) begin
                gnt_o[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/umi_switch_arbiter.sv
// ---------------------------------------------------------------------------
// umi_switch_arbiter
// Per-output arbiter for the UMI switch.  Picks one of N requesters for a
// single output port, returns ready to the winner only, and holds the grant
// from the first beat of a packet until its EOM beat is accepted.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   arbmode   [2]         00 round-robin, 01 fixed priority, 10 aging, 11 = 00
//   arbmask   [N]         1 = excluded from new arbitration
//   req_valid [N]         per-requester valid
//   req_eom   [N]         per-requester end-of-message flag
//   req_ready [N]         per-requester ready (grant & out_ready)
//   out_ready             downstream ready
//   out_valid             valid of the granted requester
//   out_eom               eom of the granted requester
//   grant     [N]         one-hot select for the output mux
//   locked                grant frozen on the registered value
// ---------------------------------------------------------------------------
module umi_switch_arbiter
    import umi_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned AGEW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   arbmode,
    input  logic [N-1:0] arbmask,
    input  logic [N-1:0] req_valid,
    input  logic [N-1:0] req_eom,
    output logic [N-1:0] req_ready,
    input  logic         out_ready,
    output logic         out_valid,
    output logic         out_eom,
    output logic [N-1:0] grant,
    output logic         locked
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    lock_state_e   lock_q, lock_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [AGEW-1:0] age_q [N];
    logic [AGEW-1:0] age_d [N];

    logic [N-1:0]  eligible;
    logic [N-1:0]  sat_elig;
    logic [IW-1:0] rr_start;
    logic [N-1:0]  gnt_rr, gnt_prio, gnt_sat;
    logic [N-1:0]  gnt_arb;
    logic          accept;
    logic          eom_accept;

    assign eligible = req_valid & ~arbmask;

    always_comb begin
        sat_elig = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sat_elig[i] = eligible[i] & (&age_q[i]);
        end
    end

    // Search begins one past the last EOM winner, wrapping at N.
    assign rr_start = (rr_ptr_q == IW'(N - 1)) ? '0 : rr_ptr_q + 1'b1;

    umi_arb_pick #(.N(N)) u_pick_rr (
        .req_i   (eligible),
        .start_i (rr_start),
        .gnt_o   (gnt_rr)
    );

    umi_arb_pick #(.N(N)) u_pick_prio (
        .req_i   (eligible),
        .start_i ('0),
        .gnt_o   (gnt_prio)
    );

    umi_arb_pick #(.N(N)) u_pick_sat (
        .req_i   (sat_elig),
        .start_i ('0),
        .gnt_o   (gnt_sat)
    );

    always_comb begin
        gnt_arb = gnt_rr;
        case (arbmode)
            ARB_PRIO: gnt_arb = gnt_prio;
            ARB_AGE:  gnt_arb = (|sat_elig) ? gnt_sat : gnt_prio;
            default:  gnt_arb = gnt_rr;
        endcase
    end

    // All handshake outputs are forced low while reset is asserted.
    always_comb begin
        grant = '0;
        if (!reset) begin
            grant = (lock_q == LK_HELD) ? grant_q : gnt_arb;
        end
    end

    assign out_valid  = |(req_valid & grant);
    assign out_eom    = |(req_eom & grant);
    assign req_ready  = grant & {N{out_ready}};
    assign locked     = (lock_q == LK_HELD) & ~reset;
    assign accept     = out_valid & out_ready;
    assign eom_accept = accept & out_eom;

    // Lock on any beat that does not finish the packet (stall or mid-packet);
    // release only on the accepted EOM beat.
    always_comb begin
        lock_d   = lock_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (out_valid && !(out_ready && out_eom)) begin
            lock_d  = LK_HELD;
            grant_d = grant;
        end else if (eom_accept) begin
            lock_d = LK_OPEN;
        end
        if (eom_accept) begin
            rr_ptr_d = IW'(oh_to_idx(32'(grant)));
        end
    end

    // Ages count only in aging mode; a completed packet clears its owner's age.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            age_d[i] = age_q[i];
            if (eom_accept && grant[i]) begin
                age_d[i] = '0;
            end else if ((arbmode == ARB_AGE) && eligible[i] && !grant[i]
                         && !(&age_q[i])) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q   <= LK_OPEN;
            grant_q  <= '0;
            rr_ptr_q <= IW'(N - 1);
            for (int unsigned i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            lock_q   <= lock_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            for (int unsigned i = 0; i < N; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_umi_switch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_umi_switch_arbiter
// Directed bench for umi_switch_arbiter (N=4, AGEW=2).  Inputs change 1 ns
// after the rising edge; outputs are compared mid-cycle.
// ---------------------------------------------------------------------------
module tb_umi_switch_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] arbmode;
    logic [3:0] arbmask;
    logic [3:0] req_valid;
    logic [3:0] req_eom;
    logic [3:0] req_ready;
    logic       out_ready;
    logic       out_valid;
    logic       out_eom;
    logic [3:0] grant;
    logic       locked;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    umi_switch_arbiter #(.N(4), .AGEW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .arbmode   (arbmode),
        .arbmask   (arbmask),
        .req_valid (req_valid),
        .req_eom   (req_eom),
        .req_ready (req_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_eom   (out_eom),
        .grant     (grant),
        .locked    (locked)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [3:0] exp_rr [5];

    initial begin
        reset     = 1'b1;
        arbmode   = 2'b00;
        arbmask   = 4'b0000;
        req_valid = 4'b1111;
        req_eom   = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_grant",  32'(grant),     32'h0);
        chk("rst_ready",  32'(req_ready), 32'h0);
        chk("rst_valid",  32'(out_valid), 32'h0);
        chk("rst_eom",    32'(out_eom),   32'h0);
        chk("rst_locked", 32'(locked),    32'h0);
        reset = 1'b0;
        tick();
        // The tick above already consumed one grant; restart cleanly.
        pulse_reset();

        // Round-robin, single-beat packets from everyone.
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("rr_grant%0d", k), 32'(grant),     32'(exp_rr[k]));
            chk($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(exp_rr[k]));
            chk($sformatf("rr_lock%0d", k),  32'(locked),    32'h0);
            tick();
        end

        // Fixed priority: 3-beat packet from req 2, req 0 joins at beat 2.
        pulse_reset();
        arbmode   = 2'b01;
        req_valid = 4'b0100;
        req_eom   = 4'b0000;
        settle();
        chk("pr_b1_grant", 32'(grant),     32'h4);
        chk("pr_b1_lock",  32'(locked),    32'h0);
        chk("pr_b1_valid", 32'(out_valid), 32'h1);
        tick();
        req_valid = 4'b0101;
        settle();
        chk("pr_b2_grant", 32'(grant),  32'h4);
        chk("pr_b2_lock",  32'(locked), 32'h1);
        tick();
        req_eom = 4'b0100;
        settle();
        chk("pr_b3_grant", 32'(grant),     32'h4);
        chk("pr_b3_eom",   32'(out_eom),   32'h1);
        chk("pr_b3_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0001;
        req_eom   = 4'b0001;
        settle();
        chk("pr_next_grant", 32'(grant),  32'h1);
        chk("pr_next_lock",  32'(locked), 32'h0);
        tick();

        // Stall: req 1 granted with out_ready low for 5 cycles.
        pulse_reset();
        arbmode   = 2'b00;
        req_valid = 4'b0010;
        req_eom   = 4'b0010;
        out_ready = 1'b0;
        settle();
        chk("st_c0_grant", 32'(grant),     32'h2);
        chk("st_c0_ready", 32'(req_ready), 32'h0);
        chk("st_c0_lock",  32'(locked),    32'h0);
        tick();
        for (int k = 1; k < 5; k++) begin
            settle();
            chk($sformatf("st_c%0d_grant", k), 32'(grant),  32'h2);
            chk($sformatf("st_c%0d_lock", k),  32'(locked), 32'h1);
            tick();
        end
        req_valid = 4'b0011;
        req_eom   = 4'b0011;
        settle();
        chk("st_c5_grant", 32'(grant),  32'h2);
        chk("st_c5_lock",  32'(locked), 32'h1);
        tick();
        out_ready = 1'b1;
        settle();
        chk("st_go_grant", 32'(grant),     32'h2);
        chk("st_go_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0001;
        req_eom   = 4'b0001;
        settle();
        chk("st_after_grant", 32'(grant),  32'h1);
        chk("st_after_lock",  32'(locked), 32'h0);
        tick();

        // Aging: req 0 streams, req 3 waits until its age saturates at 3.
        pulse_reset();
        arbmode   = 2'b10;
        req_valid = 4'b1001;
        req_eom   = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("ag_c%0d_grant", k), 32'(grant), 32'h1);
            tick();
        end
        settle();
        chk("ag_c3_grant", 32'(grant),  32'h8);
        chk("ag_c3_lock",  32'(locked), 32'h0);
        tick();
        settle();
        chk("ag_c4_grant", 32'(grant), 32'h1);
        tick();

        // Mask excludes req 0; clearing it grants in the same cycle.
        pulse_reset();
        arbmode   = 2'b01;
        arbmask   = 4'b0001;
        req_valid = 4'b0001;
        req_eom   = 4'b0001;
        settle();
        chk("mk_on_valid", 32'(out_valid), 32'h0);
        chk("mk_on_grant", 32'(grant),     32'h0);
        arbmask = 4'b0000;
        settle();
        chk("mk_off_grant", 32'(grant),     32'h1);
        chk("mk_off_valid", 32'(out_valid), 32'h1);
        tick();

        // Reset in the middle of a locked 4-beat packet.
        pulse_reset();
        arbmode   = 2'b00;
        req_valid = 4'b0010;
        req_eom   = 4'b0010;
        settle();
        chk("rm_pre_grant", 32'(grant), 32'h2);
        tick();
        req_valid = 4'b0100;
        req_eom   = 4'b0000;
        settle();
        chk("rm_b1_grant", 32'(grant), 32'h4);
        tick();
        req_eom = 4'b0100;
        reset   = 1'b1;
        settle();
        chk("rm_rst_grant", 32'(grant),     32'h0);
        chk("rm_rst_valid", 32'(out_valid), 32'h0);
        chk("rm_rst_eom",   32'(out_eom),   32'h0);
        chk("rm_rst_ready", 32'(req_ready), 32'h0);
        chk("rm_rst_lock",  32'(locked),    32'h0);
        tick();
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_eom   = 4'b0000;
        settle();
        chk("rm_post_grant", 32'(grant),  32'h1);
        chk("rm_post_lock",  32'(locked), 32'h0);
        tick();
        // Locked owner drops valid: grant is held, out_valid falls.
        req_valid = 4'b0000;
        settle();
        chk("rm_drop_lock",  32'(locked),    32'h1);
        chk("rm_drop_grant", 32'(grant),     32'h1);
        chk("rm_drop_valid", 32'(out_valid), 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/umi_switch_arbiter.md
# umi_switch_arbiter

Per-output arbiter for the UMI switch. It picks one of N requesting inputs for a single output port and steers the ready handshake back to the winner. Once a packet starts, the grant is held until the end-of-message (EOM) beat is accepted, so multi-beat transactions are never interleaved. One instance sits in front of each switch output mux and supplies its one-hot select.

## Interface

Parameters:
- N, 4, number of requesters.
- AGEW, 4, width of per-requester starvation age counter (aging mode).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- arbmode  input  2  00 round-robin, 01 fixed priority (index 0 highest), 10 priority with aging, 11 treated as 00.
- arbmask  input  N  1 = requester excluded from new arbitration.
- req_valid  input  N  per-requester valid.
- req_eom  input  N  per-requester EOM flag of the current beat (cmd bit 22 upstream).
- req_ready  output  N  per-requester ready; equals grant[i] & out_ready.
- out_ready  input  1  downstream ready.
- out_valid  output  1  |(req_valid & grant).
- out_eom  output  1  req_eom of the granted requester.
- grant  output  N  one-hot select (all-zero when nothing is granted).
- locked  output  1  arbitration frozen on the registered grant.

## Operation

- Accept = out_valid & out_ready.
- Two regimes: unlocked (grant computed combinationally from the current requests) and locked (grant = grant_q register).
- Lock rule, evaluated every cycle:
  - If out_valid & !(out_ready & out_eom): locked_next = 1 and grant_q <= grant.
  - If accept & out_eom: locked_next = 0.
  - Otherwise locked holds.
- The lock rule covers both stalled beats (valid without ready) and mid-packet beats.
- While locked, grant never changes. arbmask and arbmode changes do not break a lock.
- If the locked requester drops valid, out_valid = 0 and the grant is still held.
- Eligible set = req_valid & ~arbmask.
- Mode 00 round-robin:
  - Search starts at index rr_ptr+1 and wraps modulo N.
  - rr_ptr <= index of the granted requester on an accept with out_eom.
- Mode 01: lowest eligible index wins.
- Mode 10 aging:
  - age[i] increments, saturating at 2^AGEW-1, each cycle i is eligible and not granted.
  - age[i] clears on an accept with out_eom from i.
  - Any saturated eligible requester beats every unsaturated one; ties go to the lowest index.
  - Otherwise the lowest eligible index wins.
- No eligible requester → grant = 0, out_valid = 0.
- Single-beat packet (eom=1 accepted on the first beat) never asserts locked.

## Timing

- Zero-cycle arbitration: a request that is eligible while unlocked is granted in the same cycle.
- A single-beat packet with out_ready high completes in 1 cycle.
- locked, grant_q, rr_ptr and age update on the clock edge after the qualifying event.
- A new arbitration happens in the cycle after the EOM accept. Back-to-back packets from different requesters have no bubble.
- Reset values: locked=0, grant_q=0, rr_ptr=N-1 (so requester 0 wins first), age=0.
- While reset=1, grant, req_ready, out_valid, out_eom and locked are all forced to 0.
- Reset asserted mid-packet abandons the lock. The first cycle after reset re-arbitrates fresh.
- arbmode changes take effect at the next unlocked cycle. Ages keep counting only while arbmode=10.

## Structure

- Package umi_arb_pkg holds:
  - arbmode constants ARB_RR=2'b00, ARB_PRIO=2'b01, ARB_AGE=2'b10.
  - A function for one-hot-to-index conversion.
- Sub-module umi_arb_pick (parameter N): takes request vector and start index, returns the one-hot first-set bit with wrap.
  - Used for the RR search, the priority search (start 0), and the saturated-age search.
- Age counters and lock/pointer registers live in the top module.

## Test plan

- Reset, then req_valid=4'b1111 with all eom=1, out_ready=1, mode 00 → grants 0,1,2,3,0 on consecutive cycles; locked stays 0.
- Mode 01, req 2 sends a 3-beat packet, req 0 requests at beat 2 → grant stays 4'b0100 until the eom beat is accepted; next cycle grant=4'b0001.
- out_ready=0 for 5 cycles while req 1 is granted and valid; then raise req 0 → grant stays 4'b0010 and locked=1; on ready, req 1 completes first.
- Mode 10, AGEW=2, req 0 streams single-beat packets continuously, req 3 is valid → req 3 is granted within 4 cycles (age saturates at 3).
- arbmask=4'b0001 with only req 0 valid → out_valid=0, grant=0; clear the mask → granted the same cycle.
- Assert reset during beat 2 of a 4-beat locked packet → outputs 0 during reset, locked=0 after; the next cycle arbitrates from rr_ptr=N-1.
